fwd_hazard_scoreboard: RTL and testbench

- Parametrised forwarding and hazard unit for the CPU pipeline.
- Tracks in-flight destination registers internally in a STAGES-deep tag pipeline that advances with the datapath. It generates per-read-port forward selects for the ID-stage instruction.
- Detects load-use hazards itself and inserts bubbles. Keeps a saturating stall counter for performance analysis.
- Sits beside the ID stage. The datapath only supplies ID-stage instruction info plus global stall/flush.

---
 rtl/fwd_hazard_scoreboard_if.sv | 43 ++++
 rtl/fwd_hazard_scoreboard.sv | 87 ++++++++
 tb/tb_fwd_hazard_scoreboard.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/fwd_hazard_scoreboard_if.sv
// ---------------------------------------------------------------------------
// fwd_hazard_scoreboard_if
// Bundles the ID-stage request and the forwarding/hazard response of the
// forwarding and hazard scoreboard.
//   master : datapath side (drives ID info, stall, flush; reads selects)
//   slave  : scoreboard side
// Signals:
//   id_valid, id_regwrite, id_memread, id_rd, id_rs, id_rs_used : ID info
//   pipe_stall, flush                                            : control
//   fwd_sel, load_use_stall, stall_cnt                           : results
// ---------------------------------------------------------------------------
interface fwd_hazard_scoreboard_if #(
   parameter int unsigned NUM_PORTS = 2,
   parameter int unsigned STAGES    = 3,
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned CNT_W     = 16
);
   localparam int unsigned SEL_W = $clog2(STAGES + 1);

   logic                          id_valid;
   logic                          id_regwrite;
   logic                          id_memread;
   logic [ADDR_W-1:0]             id_rd;
   logic [NUM_PORTS*ADDR_W-1:0]   id_rs;
   logic [NUM_PORTS-1:0]          id_rs_used;
   logic                          pipe_stall;
   logic                          flush;
   logic [NUM_PORTS*SEL_W-1:0]    fwd_sel;
   logic                          load_use_stall;
   logic [CNT_W-1:0]              stall_cnt;

   modport master (
      output id_valid, id_regwrite, id_memread, id_rd, id_rs, id_rs_used,
      output pipe_stall, flush,
      input  fwd_sel, load_use_stall, stall_cnt
   );

   modport slave (
      input  id_valid, id_regwrite, id_memread, id_rd, id_rs, id_rs_used,
      input  pipe_stall, flush,
      output fwd_sel, load_use_stall, stall_cnt
   );
endinterface

// File: rtl/fwd_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// fwd_hazard_scoreboard
// Tracks in-flight destination tags of the STAGES downstream pipeline stages,
// produces per-port forward selects for the ID instruction, detects load-use
// hazards and inserts bubbles, and counts load-use stall cycles.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : fwd_hazard_scoreboard_if.slave (ID info in, selects/stall out)
// ---------------------------------------------------------------------------
module fwd_hazard_scoreboard #(
   parameter int unsigned NUM_PORTS  = 2,
   parameter int unsigned STAGES     = 3,
   parameter int unsigned LOAD_STAGE = 3,
   parameter int unsigned ADDR_W     = 5,
   parameter int unsigned CNT_W      = 16
) (
   input logic                    clk,
   input logic                    rst,
   fwd_hazard_scoreboard_if.slave bus
);
   localparam int unsigned SEL_W = $clog2(STAGES + 1);

   // Tag pipeline; index 1 is EX, index STAGES is the oldest stage
   logic [STAGES:1]      r_valid;
   logic [STAGES:1]      r_regwrite;
   logic [STAGES:1]      r_memread;
   logic [ADDR_W-1:0]    r_rd [1:STAGES];
   logic [CNT_W-1:0]     r_stall_cnt;

   logic [NUM_PORTS*SEL_W-1:0] w_fwd_sel;
   logic [NUM_PORTS-1:0]       w_hazard;
   logic [ADDR_W-1:0]          w_rs;
   logic                       w_found;
   logic                       w_load_use;

   // Youngest matching writer per port; hazard if it is a load not yet forwardable
   always_comb begin
      w_fwd_sel = '0;
      w_hazard  = '0;
      w_rs      = '0;
      w_found   = 1'b0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         w_rs    = bus.id_rs[p*ADDR_W +: ADDR_W];
         w_found = 1'b0;
         for (int unsigned k = 1; k <= STAGES; k++) begin
            if (!w_found && r_valid[k] && r_regwrite[k] &&
                (r_rd[k] == w_rs) && (w_rs != '0)) begin
               w_found                    = 1'b1;
               w_fwd_sel[p*SEL_W +: SEL_W] = SEL_W'(k);
               w_hazard[p]                = bus.id_rs_used[p] && r_memread[k] &&
                                            (k < LOAD_STAGE);
            end
         end
      end
   end

   assign w_load_use         = bus.id_valid & ~bus.flush & (|w_hazard);
   assign bus.fwd_sel        = w_fwd_sel;
   assign bus.load_use_stall = w_load_use;
   assign bus.stall_cnt      = r_stall_cnt;

   // Tag shift pipeline; only valid bits need reset, payload follows valid
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid     <= '0;
         r_stall_cnt <= '0;
      end else if (!bus.pipe_stall) begin
         for (int unsigned k = STAGES; k >= 2; k--) begin
            r_valid[k]    <= r_valid[k-1];
            r_regwrite[k] <= r_regwrite[k-1];
            r_memread[k]  <= r_memread[k-1];
            r_rd[k]       <= r_rd[k-1];
         end
         r_valid[1]    <= bus.id_valid & ~bus.flush & ~w_load_use;
         r_regwrite[1] <= bus.id_regwrite;
         r_memread[1]  <= bus.id_memread;
         r_rd[1]       <= bus.id_rd;
         if (w_load_use && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
      end else if (bus.flush) begin
         // Frozen pipeline: a redirect still kills the youngest tracked entry
         r_valid[1] <= 1'b0;
      end
   end
endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
module tb_fwd_hazard_scoreboard;
   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   fwd_hazard_scoreboard_if #(.CNT_W(16)) bus ();
   fwd_hazard_scoreboard_if #(.CNT_W(2))  bus2 ();

   fwd_hazard_scoreboard #(.CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
   fwd_hazard_scoreboard #(.CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

   // Small-counter instance sees identical stimulus
   assign bus2.id_valid    = bus.id_valid;
   assign bus2.id_regwrite = bus.id_regwrite;
   assign bus2.id_memread  = bus.id_memread;
   assign bus2.id_rd       = bus.id_rd;
   assign bus2.id_rs       = bus.id_rs;
   assign bus2.id_rs_used  = bus.id_rs_used;
   assign bus2.pipe_stall  = bus.pipe_stall;
   assign bus2.flush       = bus.flush;

   logic [1:0] sel0, sel1;
   assign sel0 = bus.fwd_sel[1:0];
   assign sel1 = bus.fwd_sel[3:2];

   task automatic drive(input logic v, input logic rw, input logic mr, input logic [4:0] rd,
                        input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] used,
                        input logic ps, input logic fl);
      bus.id_valid    = v;
      bus.id_regwrite = rw;
      bus.id_memread  = mr;
      bus.id_rd       = rd;
      bus.id_rs       = {rs1, rs0};
      bus.id_rs_used  = used;
      bus.pipe_stall  = ps;
      bus.flush       = fl;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      // Fill the pipeline with writers, then reset with random inputs applied
      rst = 1'b0;
      drive(1, 1, 0, 5'd6, 0, 0, 0, 0, 0);
      tick();
      tick();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         drive(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom),
               5'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
         tick();
      end
      rst = 1'b0;
      drive(1, 0, 0, 0, 5'd6, 5'd6, 2'b11, 1, 0);
      total++; if (bus.fwd_sel !== 4'd0) begin bad++; $display("FAIL reset_fwd_sel got=%0d exp=0", bus.fwd_sel); end
      total++; if (bus.load_use_stall !== 1'b0) begin bad++; $display("FAIL reset_lus got=%b exp=0", bus.load_use_stall); end
      total++; if (bus.stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", bus.stall_cnt); end
      total++; if (bus2.stall_cnt !== 2'd0) begin bad++; $display("FAIL reset_cnt2 got=%0d exp=0", bus2.stall_cnt); end
   endtask

   task automatic test_alu_distance();
      logic [1:0] exp_sel [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
      do_reset();
      drive(1, 1, 0, 5'd5, 0, 0, 0, 0, 0);
      tick();
      drive(1, 0, 0, 5'd0, 5'd5, 0, 2'b01, 0, 0);
      for (int i = 0; i < 4; i++) begin
         total++; if (sel0 !== exp_sel[i]) begin bad++; $display("FAIL alu_dist%0d got=%0d exp=%0d", i, sel0, exp_sel[i]); end
         tick();
         drive(0, 0, 0, 5'd0, 5'd5, 0, 2'b01, 0, 0);
      end
   endtask

   task automatic test_priority();
      do_reset();
      drive(1, 1, 0, 5'd7, 0, 0, 0, 0, 0);
      tick();
      drive(1, 1, 0, 5'd7, 0, 0, 0, 0, 0);
      tick();
      drive(1, 0, 0, 5'd0, 0, 5'd7, 2'b10, 0, 0);
      total++; if (sel1 !== 2'd1) begin bad++; $display("FAIL prio_first got=%0d exp=1", sel1); end
      tick();
      drive(0, 0, 0, 5'd0, 0, 5'd7, 2'b10, 0, 0);
      total++; if (sel1 !== 2'd2) begin bad++; $display("FAIL prio_second got=%0d exp=2", sel1); end
   endtask

   task automatic test_load_use();
      do_reset();
      drive(1, 1, 1, 5'd9, 0, 0, 0, 0, 0);
      total++; if (bus.load_use_stall !== 1'b0) begin bad++; $display("FAIL lu_t got=%b exp=0", bus.load_use_stall); end
      tick();
      drive(1, 1, 0, 5'd10, 5'd9, 0, 2'b01, 0, 0);
      total++; if (bus.load_use_stall !== 1'b1) begin bad++; $display("FAIL lu_t1 got=%b exp=1", bus.load_use_stall); end
      total++; if (sel0 !== 2'd1) begin bad++; $display("FAIL lu_t1_sel got=%0d exp=1", sel0); end
      tick();
      total++; if (bus.load_use_stall !== 1'b1) begin bad++; $display("FAIL lu_t2 got=%b exp=1", bus.load_use_stall); end
      total++; if (sel0 !== 2'd2) begin bad++; $display("FAIL lu_t2_sel got=%0d exp=2", sel0); end
      tick();
      total++; if (bus.load_use_stall !== 1'b0) begin bad++; $display("FAIL lu_t3 got=%b exp=0", bus.load_use_stall); end
      total++; if (sel0 !== 2'd3) begin bad++; $display("FAIL lu_t3_sel got=%0d exp=3", sel0); end
      total++; if (bus.stall_cnt !== 16'd2) begin bad++; $display("FAIL lu_cnt got=%0d exp=2", bus.stall_cnt); end
      tick();
      // Reader (writes x10) must now sit in stage 1, after the two bubbles
      drive(0, 0, 0, 5'd0, 5'd10, 0, 2'b00, 0, 0);
      total++; if (sel0 !== 2'd1) begin bad++; $display("FAIL lu_reader_s1 got=%0d exp=1", sel0); end
   endtask

   task automatic test_mask_x0();
      do_reset();
      drive(1, 1, 1, 5'd0, 0, 0, 0, 0, 0);
      tick();
      drive(1, 0, 0, 5'd0, 5'd0, 5'd0, 2'b11, 0, 0);
      total++; if (sel0 !== 2'd0) begin bad++; $display("FAIL x0_sel got=%0d exp=0", sel0); end
      total++; if (bus.load_use_stall !== 1'b0) begin bad++; $display("FAIL x0_lus got=%b exp=0", bus.load_use_stall); end
      do_reset();
      drive(1, 1, 1, 5'd4, 0, 0, 0, 0, 0);
      tick();
      drive(1, 0, 0, 5'd0, 5'd0, 5'd4, 2'b01, 0, 0);
      total++; if (sel1 !== 2'd1) begin bad++; $display("FAIL mask_sel got=%0d exp=1", sel1); end
      total++; if (bus.load_use_stall !== 1'b0) begin bad++; $display("FAIL mask_lus got=%b exp=0", bus.load_use_stall); end
      // Both ports read x4; only port 1 is marked as used
      drive(1, 0, 0, 5'd0, 5'd4, 5'd4, 2'b10, 0, 0);
      total++; if (bus.fwd_sel !== 4'b0101) begin bad++; $display("FAIL both_ports got=%b exp=0101", bus.fwd_sel); end
      total++; if (bus.load_use_stall !== 1'b1) begin bad++; $display("FAIL port1_lus got=%b exp=1", bus.load_use_stall); end
   endtask

   task automatic test_freeze_flush();
      do_reset();
      drive(1, 1, 1, 5'd3, 0, 0, 0, 0, 0);
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 0, 5'd0, 5'd3, 0, 2'b01, 1, 0);
         total++; if (bus.load_use_stall !== 1'b1) begin bad++; $display("FAIL frz_lus%0d got=%b exp=1", i, bus.load_use_stall); end
         total++; if (sel0 !== 2'd1) begin bad++; $display("FAIL frz_sel%0d got=%0d exp=1", i, sel0); end
         tick();
      end
      total++; if (bus.stall_cnt !== 16'd0) begin bad++; $display("FAIL frz_cnt got=%0d exp=0", bus.stall_cnt); end
      drive(1, 0, 0, 5'd0, 5'd3, 0, 2'b01, 1, 1);
      total++; if (bus.load_use_stall !== 1'b0) begin bad++; $display("FAIL flush_lus got=%b exp=0", bus.load_use_stall); end
      tick();
      drive(1, 0, 0, 5'd0, 5'd3, 0, 2'b01, 0, 0);
      total++; if (sel0 !== 2'd0) begin bad++; $display("FAIL flush_clear got=%0d exp=0", sel0); end
      total++; if (bus.load_use_stall !== 1'b0) begin bad++; $display("FAIL flush_after_lus got=%b exp=0", bus.load_use_stall); end
      total++; if (bus.stall_cnt !== 16'd0) begin bad++; $display("FAIL flush_cnt got=%0d exp=0", bus.stall_cnt); end
   endtask

   task automatic test_back_to_back_saturate();
      do_reset();
      // Two load/reader pairs give 4 stall cycles; the 2-bit counter stops at 3
      for (int n = 0; n < 2; n++) begin
         drive(1, 1, 1, 5'd9, 0, 0, 0, 0, 0);
         tick();
         drive(1, 0, 0, 5'd0, 5'd9, 0, 2'b01, 0, 0);
         tick();
         tick();
         tick();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      total++; if (bus.stall_cnt !== 16'd4) begin bad++; $display("FAIL b2b_cnt got=%0d exp=4", bus.stall_cnt); end
      total++; if (bus2.stall_cnt !== 2'd3) begin bad++; $display("FAIL sat_cnt got=%0d exp=3", bus2.stall_cnt); end
   endtask

   initial begin
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      test_reset();
      test_alu_distance();
      test_priority();
      test_load_use();
      test_mask_x0();
      test_freeze_flush();
      test_back_to_back_saturate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
